apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
//  - APB3 completer: byte-wide register/memory slave behind the APB master (downstream stage).
//  - Decodes PSEL/PENABLE phases and inserts a programmable number of wait states via PREADY.
//  - Serves reads and writes, and flags out-of-range accesses on PSLVERR.
//  - Two instances sit under the master's slave-select; master PADDR[8] picks the instance
//    and PADDR[7:0] connects to this block.
// PARAMETERS
//  ADDR_W       8   PADDR width
//  DATA_W       8   PWDATA/PRDATA width
//  DEPTH        64  implemented locations 0..DEPTH-1 (DEPTH <= 2**ADDR_W)
//  WAIT_CYCLES  1   extra wait states, 0..15 (total wait states = WAIT_CYCLES+1)
// PORTS
//  PCLK     in   1       clock, all logic on rising edge
//  PRESETn  in   1       reset, asynchronous assert, active-low
//  PSEL     in   1       slave select from master
//  PENABLE  in   1       access-phase indicator
//  PWRITE   in   1       1 = write, 0 = read
//  PADDR    in   ADDR_W  byte address
//  PWDATA   in   DATA_W  write data
//  PREADY   out  1       transfer-complete strobe (registered)
//  PRDATA   out  DATA_W  read data, valid while PREADY=1 on a read (registered)
//  PSLVERR  out  1       error response, valid while PREADY=1 (registered)
// BEHAVIOUR
//  - Reset (PRESETn=0, any time, including mid-transfer): state=IDLE, PREADY=0, PRDATA=0,
//    PSLVERR=0, all mem locations=0, all written-flags=0, wait counter=0.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE:
//    - On PSEL=1 & PENABLE=0 (setup) at edge: latch PADDR/PWRITE/PWDATA, cnt<=WAIT_CYCLES, ->WAIT.
//    - Otherwise remain in IDLE.
//  - WAIT (PREADY=0):
//    - If PSEL=0: abort to IDLE, with no write and no response.
//    - Else if cnt!=0: cnt<=cnt-1.
//    - Else (cnt==0): execute the access, drive PREADY<=1, ->RESP.
//  - Execute, in-range (addr<DEPTH):
//    - Write: mem[addr]<=data, PSLVERR<=0.
//    - Read: PRDATA<=mem[addr], PSLVERR<=0.
//  - Execute, out-of-range (addr>=DEPTH): no write, PRDATA<=0, PSLVERR<=1.
//  - RESP:
//    - PREADY=1 for exactly one cycle.
//    - At next edge: PREADY<=0, PSLVERR<=0, ->IDLE.
//    - PRDATA holds its value until the next read.
//  - Latency: setup edge E0. PREADY is high during the (WAIT_CYCLES+2)th access cycle.
//    Example: WAIT_CYCLES=1 -> PREADY high 3 cycles after the setup cycle.
//  - Back-to-back: a setup phase in the cycle right after RESP is accepted (RESP->IDLE->WAIT)
//    with no bubble beyond the protocol's own setup cycle.
//  - Write commit happens on the edge that raises PREADY; a read in the next transfer sees the new data.
//  - Address/data changes by the master during WAIT are ignored; values are latched at setup.
//  - PENABLE=0 while in WAIT with PSEL=1 is treated as a new setup: relatch and restart the count.
//  - PSLVERR and PRDATA are never asserted or updated while PREADY=0.
// CONFIGURATION
//  - Macro APB_SLV_UNWRITTEN_ERR_EN:
//    - Defined: one written-flag per location, set on in-range write, cleared only by reset.
//      An in-range read of a location whose flag=0 returns PRDATA=0 with PSLVERR=1.
//    - Undefined: no flags are implemented; reads of unwritten locations return 0
//      (the reset value) with PSLVERR=0.
// TESTING
//  (WAIT_CYCLES=1, DEPTH=64 unless noted)
//  1. Reset mid-transfer:
//     Assert PRESETn=0 during WAIT of a write to addr 5.
//     -> PREADY/PSLVERR/PRDATA=0 immediately; a later read of 5 returns 0x00; mem unchanged.
//  2. Write/readback:
//     Write addr 0..7 with data 2*i, then read 0..7.
//     -> PRDATA=0x00,0x02..0x0E; PSLVERR=0; each PREADY high 3 cycles after setup.
//  3. Out-of-range:
//     Write 0x09 to addr 70, then read addr 70.
//     -> PSLVERR=1 on both; PRDATA=0; mem[70-64] contents unchanged.
//  4. Unwritten read:
//     After reset, read addr 45.
//     -> with APB_SLV_UNWRITTEN_ERR_EN: PSLVERR=1, PRDATA=0.
//     -> without the macro: PSLVERR=0, PRDATA=0.
//  5. Abort:
//     Drop PSEL during WAIT of a write 0xAA to addr 3.
//     -> PREADY never asserts; a subsequent read of 3 returns its prior value.
//  6. Back-to-back and latency:
//     WAIT_CYCLES=0: write 0x11 to addr 1 immediately followed by a read of addr 1.
//     -> PREADY high in the 2nd access cycle of each transfer; the read returns 0x11.

Source files
------------

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 byte-wide memory completer with programmable wait states
// Optional macro APB_SLV_UNWRITTEN_ERR_EN: error response on reads of never-written locations.
module apb_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   prdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef APB_SLV_UNWRITTEN_ERR_EN
    logic [DEPTH-1:0]    wflag_q;
`endif

    logic                in_range;
    logic [IDX_W-1:0]    idx;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef APB_SLV_UNWRITTEN_ERR_EN
            wflag_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        cnt_q   <= WAIT_L;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!PSEL) begin
                        state_q <= S_IDLE;
                    end else if (!PENABLE) begin
                        // A fresh setup phase while waiting restarts the transfer.
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        cnt_q   <= WAIT_L;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        pready_q <= 1'b1;
                        state_q  <= S_RESP;
                        if (!in_range) begin
                            prdata_q  <= '0;
                            pslverr_q <= 1'b1;
                        end else if (write_q) begin
                            mem_q[idx] <= wdata_q;
                            pslverr_q  <= 1'b0;
`ifdef APB_SLV_UNWRITTEN_ERR_EN
                            wflag_q[idx] <= 1'b1;
`endif
                        end else begin
`ifdef APB_SLV_UNWRITTEN_ERR_EN
                            if (!wflag_q[idx]) begin
                                prdata_q  <= '0;
                                pslverr_q <= 1'b1;
                            end else begin
                                prdata_q  <= mem_q[idx];
                                pslverr_q <= 1'b0;
                            end
`else
                            prdata_q  <= mem_q[idx];
                            pslverr_q <= 1'b0;
`endif
                        end
                    end
                end
                S_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem (WAIT_CYCLES 0 and 1 instances)
module tb_apb_slave_mem;

    logic       clk;
    logic       rst_n;
    logic [1:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [1:0] pready;
    logic [1:0] pslverr;
    logic [7:0] prdata [2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] m_mem [2][64];
    bit         m_wr  [2][64];
    logic [7:0] m_prd [2];

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_prd[d] = 8'h00;
            for (int i = 0; i < 64; i++) begin
                m_mem[d][i] = 8'h00;
                m_wr[d][i]  = 1'b0;
            end
        end
    endtask

    task automatic model_access(input int d, input logic wr, input logic [7:0] a,
                                input logic [7:0] wd, output exp_t e);
        e.lat = (d == 1) ? 3 : 2;
        if (a >= 8'd64) begin
            e.rd  = 8'h00;
            e.err = 1'b1;
        end else if (wr) begin
            m_mem[d][a[5:0]] = wd;
            m_wr[d][a[5:0]]  = 1'b1;
            e.rd  = m_prd[d];
            e.err = 1'b0;
        end else begin
`ifdef APB_SLV_UNWRITTEN_ERR_EN
            e.rd  = m_wr[d][a[5:0]] ? m_mem[d][a[5:0]] : 8'h00;
            e.err = !m_wr[d][a[5:0]];
`else
            e.rd  = m_mem[d][a[5:0]];
            e.err = 1'b0;
`endif
        end
        m_prd[d] = e.rd;
    endtask

    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        exp_t e;
        exp_t g;
        int   cyc;
        bit   got;
        model_access(d, wr, a, wd, e);
        sb.push_back(e);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge clk);
        chk("setup_pready_low", 32'(pready[d]), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            if (pready[d]) got = 1'b1;
            else begin
                cyc++;
                @(posedge clk); #1;
            end
        end
        g = sb.pop_front();
        if (!got) begin
            chk("pready_timeout", 32'd0, 32'd1);
        end else begin
            chk($sformatf("prdata a=%0d", a), 32'(prdata[d]), 32'(g.rd));
            chk($sformatf("pslverr a=%0d", a), 32'(pslverr[d]), 32'(g.err));
            chk($sformatf("latency a=%0d", a), 32'(cyc), 32'(g.lat));
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_pready", 32'(pready[d]), 32'd0);
            chk("reset_pslverr", 32'(pslverr[d]), 32'd0);
            chk("reset_prdata", 32'(prdata[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unwritten read straight after reset
        xfer(1, 1'b0, 8'd45, 8'h00);
        idle();

        // Write 0..7 with 2*i then read back
        for (int i = 0; i < 8; i++) xfer(1, 1'b1, 8'(i), 8'(2 * i));
        for (int i = 0; i < 8; i++) xfer(1, 1'b0, 8'(i), 8'h00);
        idle();

        // Out-of-range write/read; aliased location 6 must be untouched
        xfer(1, 1'b1, 8'd70, 8'h09);
        xfer(1, 1'b0, 8'd70, 8'h00);
        xfer(1, 1'b0, 8'd6, 8'h00);
        chk("alias_mem6", 32'(prdata[1]), 32'h0C);
        idle();

        // Abort: PSEL drops during the wait of a write 0xAA to addr 3
        @(posedge clk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 8'hAA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pready[1]) seen++;
        end
        chk("abort_pready", 32'(seen), 32'd0);
        xfer(1, 1'b0, 8'd3, 8'h00);
        chk("abort_mem3", 32'(prdata[1]), 32'h06);
        idle();

        // Reset during the wait of a write to addr 5, with PRDATA holding a nonzero value
        xfer(1, 1'b0, 8'd5, 8'h00);
        idle();
        @(posedge clk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5; pwdata = 8'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready[1]), 32'd0);
        chk("midrst_pslverr", 32'(pslverr[1]), 32'd0);
        chk("midrst_prdata", 32'(prdata[1]), 32'd0);
        model_reset();
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1, 1'b0, 8'd5, 8'h00);
        chk("midrst_mem5", 32'(prdata[1]), 32'h00);
        idle();

        // Zero wait states, back-to-back write then read
        xfer(0, 1'b1, 8'd1, 8'h11);
        xfer(0, 1'b0, 8'd1, 8'h00);
        chk("b2b_read", 32'(prdata[0]), 32'h11);
        idle();
        @(negedge clk);
        chk("final_pready0", 32'(pready[0]), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
